// File: rtl/dcache_store_buffer.sv
// Retired-store buffer between the LSQ and the dcache request port.
// Holds committed stores in a circular FIFO, drains them to the dcache in
// program order, shares the single dcache port with LSQ loads, and forwards
// buffered store data to loads that hit a buffered doubleword.

`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

module dcache_store_buffer #(
  parameter int SB_DEPTH    = 4,
  parameter int SB_IDX_BITS = 2,
  parameter int AGE_LIMIT   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   lsq2sb_st_valid,
  input  logic [63:0]            lsq2sb_st_addr,
  input  logic [63:0]            lsq2sb_st_data,
  output logic                   sb2lsq_st_ready,
  input  logic                   lsq2sb_ld_valid,
  input  logic [63:0]            lsq2sb_ld_addr,
  output logic                   sb2lsq_fwd_hit,
  output logic [63:0]            sb2lsq_fwd_data,
  output logic [3:0]             sb2lsq_ld_response,
  output logic [1:0]             sb2Dcache_command,
  output logic [63:0]            sb2Dcache_addr,
  output logic [63:0]            sb2Dcache_data,
  input  logic [3:0]             Dcache2sb_response,
  output logic                   sb_empty,
  output logic [SB_IDX_BITS:0]   sb_count
);

  localparam logic [SB_IDX_BITS:0] FULL_CNT = SB_DEPTH[SB_IDX_BITS:0];
  localparam logic [1:0]           AGE_LIM  = AGE_LIMIT[1:0];

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } sb_entry_t;

  sb_entry_t [SB_DEPTH-1:0]  r_ent;
  logic [SB_DEPTH-1:0]       r_vld;
  logic [SB_IDX_BITS-1:0]    r_head;
  logic [SB_IDX_BITS-1:0]    r_tail;
  logic [SB_IDX_BITS:0]      r_count;
  logic [1:0]                r_age;
  // head store lost its handshake last cycle; keep it on the port
  logic                      r_retry;

  logic                      w_full;
  logic                      w_nonempty;
  logic                      w_enq;
  logic                      w_deq;
  logic                      w_st_own;
  logic                      w_ld_own;
  logic [SB_DEPTH-1:0]       w_match;
  logic                      w_hit;
  logic [63:0]               w_fdata;
  logic [SB_IDX_BITS-1:0]    w_idx;

  assign w_full     = (r_count == FULL_CNT);
  assign w_nonempty = (r_count != '0);

  // doubleword compare of the load against every live entry
  for (genvar g = 0; g < SB_DEPTH; g++) begin : g_cmp
    assign w_match[g] = r_vld[g] && (r_ent[g].addr[63:3] == lsq2sb_ld_addr[63:3]);
  end

  // walk oldest->youngest from head so the last hit seen is the youngest
  always_comb begin
    w_hit   = 1'b0;
    w_fdata = '0;
    w_idx   = r_head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_idx = r_head + SB_IDX_BITS'(i);
      if (lsq2sb_ld_valid && w_match[w_idx]) begin
        w_hit   = 1'b1;
        w_fdata = r_ent[w_idx].data;
      end
    end
  end

  // forwarded loads are satisfied here, so they never compete for the port
  assign w_st_own = w_nonempty && (!lsq2sb_ld_valid || w_hit || w_full ||
                                   (r_age >= AGE_LIM) || r_retry);
  assign w_ld_own = lsq2sb_ld_valid && !w_hit && !w_st_own;

  assign w_enq = lsq2sb_st_valid && sb2lsq_st_ready;
  assign w_deq = w_st_own && (Dcache2sb_response != 4'h0);

  assign sb2lsq_st_ready    = !w_full;
  assign sb2lsq_fwd_hit     = w_hit;
  assign sb2lsq_fwd_data    = w_fdata;
  assign sb2lsq_ld_response = w_ld_own ? Dcache2sb_response : 4'h0;
  assign sb_empty           = !w_nonempty;
  assign sb_count           = r_count;

  // dcache request mux for whichever side owns the port
  always_comb begin
    sb2Dcache_command = `BUS_NONE;
    sb2Dcache_addr    = '0;
    sb2Dcache_data    = '0;
    if (w_st_own) begin
      sb2Dcache_command = `BUS_STORE;
      sb2Dcache_addr    = r_ent[r_head].addr;
      sb2Dcache_data    = r_ent[r_head].data;
    end else if (w_ld_own) begin
      sb2Dcache_command = `BUS_LOAD;
      sb2Dcache_addr    = lsq2sb_ld_addr;
    end
  end

  // FIFO pointers, entries, occupancy, starvation age and retry hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ent   <= '0;
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_age   <= '0;
      r_retry <= 1'b0;
    end else begin
      if (w_enq) begin
        r_ent[r_tail] <= '{addr: lsq2sb_st_addr, data: lsq2sb_st_data};
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + SB_IDX_BITS'(1);
      end
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + SB_IDX_BITS'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (SB_IDX_BITS+1)'(1);
        2'b01:   r_count <= r_count - (SB_IDX_BITS+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_nonempty && w_ld_own)
        r_age <= (r_age == 2'b11) ? r_age : r_age + 2'd1;
      else
        r_age <= '0;
      r_retry <= w_st_own && (Dcache2sb_response == 4'h0);
    end
  end

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed bench for dcache_store_buffer: a vector table for in-order drain,
// full-buffer backpressure and load starvation, plus hand sequences for
// forwarding, pointer wrap and asynchronous reset during a drain.

module tb_dcache_store_buffer;

  localparam logic [1:0] B_NONE  = 2'h0;
  localparam logic [1:0] B_LOAD  = 2'h1;
  localparam logic [1:0] B_STORE = 2'h2;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [63:0] st_addr, st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic        fwd_hit;
  logic [63:0] fwd_data;
  logic [3:0]  ld_resp;
  logic [1:0]  cmd;
  logic [63:0] dc_addr, dc_data;
  logic [3:0]  resp;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dcache_store_buffer dut (
    .clock              (clock),
    .reset              (reset),
    .lsq2sb_st_valid    (st_valid),
    .lsq2sb_st_addr     (st_addr),
    .lsq2sb_st_data     (st_data),
    .sb2lsq_st_ready    (st_ready),
    .lsq2sb_ld_valid    (ld_valid),
    .lsq2sb_ld_addr     (ld_addr),
    .sb2lsq_fwd_hit     (fwd_hit),
    .sb2lsq_fwd_data    (fwd_data),
    .sb2lsq_ld_response (ld_resp),
    .sb2Dcache_command  (cmd),
    .sb2Dcache_addr     (dc_addr),
    .sb2Dcache_data     (dc_data),
    .Dcache2sb_response (resp),
    .sb_empty           (empty),
    .sb_count           (count)
  );

  typedef struct {
    logic        stv;
    logic [63:0] sta, std;
    logic        ldv;
    logic [63:0] lda;
    logic [3:0]  rsp;
    logic [1:0]  cmd;
    logic [63:0] addr, data;
    logic        hit;
    logic [63:0] fdata;
    logic [3:0]  lresp;
    logic        rdy;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic stv, input logic [63:0] sta, input logic [63:0] std,
                              input logic ldv, input logic [63:0] lda, input logic [3:0] rsp,
                              input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                              input logic h, input logic [63:0] fd, input logic [3:0] lr,
                              input logic rdy, input logic [2:0] cnt);
    vec_t v;
    v.stv = stv; v.sta = sta; v.std = std; v.ldv = ldv; v.lda = lda; v.rsp = rsp;
    v.cmd = c; v.addr = a; v.data = d; v.hit = h; v.fdata = fd; v.lresp = lr;
    v.rdy = rdy; v.cnt = cnt;
    return v;
  endfunction

  task automatic setin(input logic stv, input logic [63:0] sta, input logic [63:0] std,
                       input logic ldv, input logic [63:0] lda, input logic [3:0] rsp);
    st_valid = stv; st_addr = sta; st_data = std;
    ld_valid = ldv; ld_addr = lda; resp = rsp;
  endtask

  // one cycle: drive after the edge, compare on the falling edge, advance
  task automatic cyc(input string tag, input vec_t v);
    setin(v.stv, v.sta, v.std, v.ldv, v.lda, v.rsp);
    @(negedge clock);
    chk({tag, ".cmd"},   cmd,      v.cmd);
    chk({tag, ".addr"},  dc_addr,  v.addr);
    chk({tag, ".data"},  dc_data,  v.data);
    chk({tag, ".hit"},   fwd_hit,  v.hit);
    chk({tag, ".fdata"}, fwd_data, v.fdata);
    chk({tag, ".lresp"}, ld_resp,  v.lresp);
    chk({tag, ".rdy"},   st_ready, v.rdy);
    chk({tag, ".cnt"},   count,    v.cnt);
    chk({tag, ".empty"}, empty,    (v.cnt == 3'd0));
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    setin(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t limit 100000", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    setin(0, 0, 0, 0, 0, 4'h1);
    #1;
    chk("rst.cmd",   cmd,      B_NONE);
    chk("rst.addr",  dc_addr,  64'h0);
    chk("rst.data",  dc_data,  64'h0);
    chk("rst.hit",   fwd_hit,  1'b0);
    chk("rst.fdata", fwd_data, 64'h0);
    chk("rst.lresp", ld_resp,  4'h0);
    chk("rst.rdy",   st_ready, 1'b1);
    chk("rst.empty", empty,    1'b1);
    chk("rst.cnt",   count,    3'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // in-order drain with response=1: one store per cycle, starting a cycle after enqueue
    tv.push_back(mk(1, 64'h100, 64'hA0, 0, 0, 1, B_NONE,  0,      0,     0, 0, 0, 1, 0));
    tv.push_back(mk(1, 64'h108, 64'hA1, 0, 0, 1, B_STORE, 64'h100, 64'hA0, 0, 0, 0, 1, 1));
    tv.push_back(mk(1, 64'h110, 64'hA2, 0, 0, 1, B_STORE, 64'h108, 64'hA1, 0, 0, 0, 1, 1));
    tv.push_back(mk(1, 64'h118, 64'hA3, 0, 0, 1, B_STORE, 64'h110, 64'hA2, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 0,       0,      0, 0, 1, B_STORE, 64'h118, 64'hA3, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 0,       0,      0, 0, 1, B_NONE,  0,      0,     0, 0, 0, 1, 0));
    // fill with response=0; 5th store backpressured, including the cycle head dequeues
    tv.push_back(mk(1, 64'h100, 64'hB0, 0, 0, 0, B_NONE,  0,      0,     0, 0, 0, 1, 0));
    tv.push_back(mk(1, 64'h108, 64'hB1, 0, 0, 0, B_STORE, 64'h100, 64'hB0, 0, 0, 0, 1, 1));
    tv.push_back(mk(1, 64'h110, 64'hB2, 0, 0, 0, B_STORE, 64'h100, 64'hB0, 0, 0, 0, 1, 2));
    tv.push_back(mk(1, 64'h118, 64'hB3, 0, 0, 0, B_STORE, 64'h100, 64'hB0, 0, 0, 0, 1, 3));
    tv.push_back(mk(1, 64'h120, 64'hB4, 0, 0, 0, B_STORE, 64'h100, 64'hB0, 0, 0, 0, 0, 4));
    tv.push_back(mk(1, 64'h120, 64'hB4, 0, 0, 1, B_STORE, 64'h100, 64'hB0, 0, 0, 0, 0, 4));
    tv.push_back(mk(1, 64'h120, 64'hB4, 0, 0, 1, B_STORE, 64'h108, 64'hB1, 0, 0, 0, 1, 3));
    tv.push_back(mk(0, 0,       0,      0, 0, 1, B_STORE, 64'h110, 64'hB2, 0, 0, 0, 1, 3));
    tv.push_back(mk(0, 0,       0,      0, 0, 1, B_STORE, 64'h118, 64'hB3, 0, 0, 0, 1, 2));
    tv.push_back(mk(0, 0,       0,      0, 0, 1, B_STORE, 64'h120, 64'hB4, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 0,       0,      0, 0, 1, B_NONE,  0,      0,     0, 0, 0, 1, 0));
    // load starvation: three missing loads win, then the aged store takes the port
    tv.push_back(mk(1, 64'h500, 64'hC0, 0, 0,       3, B_NONE,  0,       0,     0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0,       0,      1, 64'h300, 3, B_LOAD,  64'h300, 0,     0, 0, 3, 1, 1));
    tv.push_back(mk(0, 0,       0,      1, 64'h300, 3, B_LOAD,  64'h300, 0,     0, 0, 3, 1, 1));
    tv.push_back(mk(0, 0,       0,      1, 64'h300, 3, B_LOAD,  64'h300, 0,     0, 0, 3, 1, 1));
    tv.push_back(mk(0, 0,       0,      1, 64'h300, 3, B_STORE, 64'h500, 64'hC0, 0, 0, 0, 1, 1));
    tv.push_back(mk(0, 0,       0,      1, 64'h300, 3, B_LOAD,  64'h300, 0,     0, 0, 3, 1, 0));
    tv.push_back(mk(0, 0,       0,      0, 0,       3, B_NONE,  0,       0,     0, 0, 0, 1, 0));

    for (int i = 0; i < tv.size(); i++)
      cyc($sformatf("vec%0d", i), tv[i]);

    // forwarding: youngest match wins, same-cycle enqueue not visible, dequeuing entry still forwards
    cyc("fwd0", mk(1, 64'h200, 64'h11, 0, 0,       0, B_NONE,  0,       0,     0, 0,     0, 1, 0));
    cyc("fwd1", mk(1, 64'h200, 64'h22, 1, 64'h200, 0, B_STORE, 64'h200, 64'h11, 1, 64'h11, 0, 1, 1));
    cyc("fwd2", mk(0, 0,       0,      1, 64'h204, 0, B_STORE, 64'h200, 64'h11, 1, 64'h22, 0, 1, 2));
    cyc("fwd3", mk(0, 0,       0,      0, 0,       1, B_STORE, 64'h200, 64'h11, 0, 0,     0, 1, 2));
    cyc("fwd4", mk(0, 0,       0,      1, 64'h200, 1, B_STORE, 64'h200, 64'h22, 1, 64'h22, 0, 1, 1));
    cyc("fwd5", mk(0, 0,       0,      0, 0,       1, B_NONE,  0,       0,     0, 0,     0, 1, 0));

    // tail wraps 3->0 on a simultaneous enq+deq at count 2, then full buffer blocks a load
    pulse_reset();
    cyc("wr0",  mk(1, 64'h600, 64'h60, 0, 0,       0, B_NONE,  0,       0,     0, 0,     0, 1, 0));
    cyc("wr1",  mk(1, 64'h608, 64'h61, 0, 0,       0, B_STORE, 64'h600, 64'h60, 0, 0,     0, 1, 1));
    cyc("wr2",  mk(1, 64'h610, 64'h62, 0, 0,       0, B_STORE, 64'h600, 64'h60, 0, 0,     0, 1, 2));
    cyc("wr3",  mk(0, 0,       0,      0, 0,       1, B_STORE, 64'h600, 64'h60, 0, 0,     0, 1, 3));
    cyc("wr4",  mk(1, 64'h618, 64'h63, 0, 0,       1, B_STORE, 64'h608, 64'h61, 0, 0,     0, 1, 2));
    cyc("wr5",  mk(1, 64'h620, 64'h64, 0, 0,       0, B_STORE, 64'h610, 64'h62, 0, 0,     0, 1, 2));
    cyc("wr6",  mk(1, 64'h628, 64'h65, 0, 0,       0, B_STORE, 64'h610, 64'h62, 0, 0,     0, 1, 3));
    cyc("wr7",  mk(1, 64'h630, 64'h66, 1, 64'h400, 2, B_STORE, 64'h610, 64'h62, 0, 0,     0, 0, 4));
    cyc("wr8",  mk(0, 0,       0,      1, 64'h620, 1, B_STORE, 64'h618, 64'h63, 1, 64'h64, 0, 1, 3));
    cyc("wr9",  mk(0, 0,       0,      0, 0,       1, B_STORE, 64'h620, 64'h64, 0, 0,     0, 1, 2));
    cyc("wr10", mk(0, 0,       0,      0, 0,       1, B_STORE, 64'h628, 64'h65, 0, 0,     0, 1, 1));
    cyc("wr11", mk(0, 0,       0,      0, 0,       1, B_NONE,  0,       0,     0, 0,     0, 1, 0));

    // asynchronous reset while three stores are draining
    cyc("md0", mk(1, 64'h700, 64'h70, 0, 0, 0, B_NONE,  0,       0,     0, 0, 0, 1, 0));
    cyc("md1", mk(1, 64'h708, 64'h71, 0, 0, 0, B_STORE, 64'h700, 64'h70, 0, 0, 0, 1, 1));
    cyc("md2", mk(1, 64'h710, 64'h72, 0, 0, 0, B_STORE, 64'h700, 64'h70, 0, 0, 0, 1, 2));
    setin(0, 0, 0, 0, 0, 4'h1);
    #1;
    chk("md.pre.cnt", count, 3'd3);
    chk("md.pre.cmd", cmd,   B_STORE);
    reset = 1'b0;
    #1;
    chk("md.async.cnt", count, 3'd0);
    chk("md.async.cmd", cmd,   B_NONE);
    @(posedge clock);
    #1;
    chk("md.post.cmd",   cmd,      B_NONE);
    chk("md.post.addr",  dc_addr,  64'h0);
    chk("md.post.empty", empty,    1'b1);
    chk("md.post.cnt",   count,    3'd0);
    chk("md.post.rdy",   st_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cyc("md3", mk(0, 0, 0, 0, 0, 1, B_NONE, 0, 0, 0, 0, 0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
